// File: rtl/i2c_target_if.sv
// I2C target bus bundle: initiator-owned scl, shared open-drain sda (pulled up
// when nobody drives it), plus the target's status outputs.
interface i2c_target_if;
   logic       scl;
   tri1        sda;
   logic [7:0] reg0;
   logic       busy;
   logic       wr_pulse;

   modport slave  (input scl, inout sda, output reg0, output busy, output wr_pulse);
   modport master (output scl, inout sda, input reg0, input busy, input wr_pulse);
endinterface

// File: rtl/i2c_target.sv
// I2C target with a 4 x 8 register file behind an auto-incrementing 2-bit pointer.
// Everything runs in the clk domain off 2-FF synchronised scl/sda.
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input logic          clk,
   input logic          rst,
   i2c_target_if.slave  bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
   } state_t;

   state_t          state;
   logic [1:0]      scl_sync, sda_sync;
   logic            scl_d, sda_d;
   logic            scl_s, sda_s;
   logic            scl_rise, scl_fall, start, stop;
   logic [3:0][7:0] regs;
   logic [1:0]      ptr;
   logic [7:0]      sh;
   logic [7:0]      byte_in;
   logic [2:0]      bit_cnt;
   logic            phase, rw, last, nack, sda_oe, busy_q, wr_q;

   assign scl_s    = scl_sync[1];
   assign sda_s    = sda_sync[1];
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d & sda_s;
   assign byte_in  = {sh[6:0], sda_s};

   assign bus.sda      = sda_oe ? 1'b0 : 1'bz;
   assign bus.reg0     = regs[0];
   assign bus.busy     = busy_q;
   assign bus.wr_pulse = wr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
         regs     <= '0;
         ptr      <= '0;
         sh       <= '0;
         bit_cnt  <= '0;
         phase    <= 1'b0;
         rw       <= 1'b0;
         last     <= 1'b0;
         nack     <= 1'b0;
         sda_oe   <= 1'b0;
         busy_q   <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[0], bus.scl};
         sda_sync <= {sda_sync[0], bus.sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
         wr_q     <= 1'b0;
         // Bus conditions win over any bit activity in the same cycle.
         if (start) begin
            state   <= S_ADDR;
            bit_cnt <= '0;
            phase   <= 1'b0;
            sda_oe  <= 1'b0;
            busy_q  <= 1'b0;
         end else if (stop) begin
            state  <= S_IDLE;
            phase  <= 1'b0;
            sda_oe <= 1'b0;
            busy_q <= 1'b0;
         end else begin
            case (state)
               S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
                  sh      <= byte_in;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     phase <= 1'b0;
                     if (state == S_ADDR) begin
                        if (byte_in[7:1] == ADDR) begin
                           state  <= S_ADDR_ACK;
                           rw     <= byte_in[0];
                           busy_q <= 1'b1;
                        end else begin
                           state <= S_IGNORE;
                        end
                     end else if (state == S_PTR) begin
                        ptr   <= byte_in[1:0];
                        state <= S_PTR_ACK;
                     end else begin
                        regs[ptr] <= byte_in;
                        wr_q      <= 1'b1;
                        ptr       <= ptr + 2'd1;
                        state     <= S_WDATA_ACK;
                     end
                  end
               end
               // First fall after bit 8 pulls sda low, the fall after bit 9 ends the ACK.
               S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                  if (!phase) begin
                     sda_oe <= 1'b1;
                     phase  <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     bit_cnt <= '0;
                     if (state == S_ADDR_ACK && rw) begin
                        state  <= S_RDATA;
                        sh     <= regs[ptr];
                        sda_oe <= ~regs[ptr][7];
                        ptr    <= ptr + 2'd1;
                        last   <= 1'b0;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                     end
                  end
               end
               S_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) last <= 1'b1;
                  end else if (scl_fall) begin
                     if (last) begin
                        sda_oe <= 1'b0;
                        phase  <= 1'b0;
                        state  <= S_RACK;
                     end else begin
                        sh     <= {sh[6:0], 1'b0};
                        sda_oe <= ~sh[6];
                     end
                  end
               end
               S_RACK: begin
                  if (scl_rise) begin
                     nack  <= sda_s;
                     phase <= 1'b1;
                  end else if (scl_fall && phase) begin
                     phase <= 1'b0;
                     if (nack) begin
                        state  <= S_IGNORE;
                        busy_q <= 1'b0;
                     end else begin
                        state   <= S_RDATA;
                        sh      <= regs[ptr];
                        sda_oe  <= ~regs[ptr][7];
                        ptr     <= ptr + 2'd1;
                        bit_cnt <= '0;
                        last    <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
